// File: rtl/tile_nv_reader.sv
// Read sequencer from tile L1 mantissa/exponent BRAMs to the compute engine stream.
// Optional stall counter enabled by defining TILE_RD_PERF_CNT_EN.
module tile_nv_reader #(
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned WIDTH      = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned NV_LINES   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_WIDTH-3:0] i_cmd_nv_start,
  input  logic [ADDR_WIDTH-2:0] i_cmd_nv_count,
  output logic [ADDR_WIDTH-1:0] o_man_rd_addr,
  output logic                  o_man_rd_en,
  input  logic [WIDTH-1:0]      i_man_rd_data,
  output logic [ADDR_WIDTH-1:0] o_exp_rd_addr,
  input  logic [7:0]            i_exp_rd_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WIDTH-1:0]      o_man_data,
  output logic [7:0]            o_exp_data,
  output logic [1:0]            o_grp_idx,
  output logic                  o_last_grp,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           o_stall_cycles
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LINE_W = ADDR_WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0] man;
    logic [7:0]       exp;
    logic [1:0]       grp;
    logic             last_grp;
    logic             last;
  } beat_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LINE_W-1:0]     total_q, total_d;
  logic [LINE_W-1:0]     issued_q, issued_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]            rd_grp_q, rd_grp_d;
  logic                  rd_last_q, rd_last_d;
  logic                  ret_q;
  logic [1:0]            ret_grp_q;
  logic                  ret_last_q;
  logic                  cmd_ready_q, busy_q, done_q;

  beat_t                 mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  accept_c, push_c, pop_c, fifo_valid_c, credit_ok_c;
  logic [CNT_W:0]        used_c;
  beat_t                 head_c, push_beat_c;

  assign accept_c     = i_cmd_valid && cmd_ready_q;
  assign push_c       = ret_q;
  assign fifo_valid_c = (cnt_q != '0);
  assign pop_c        = fifo_valid_c && i_ready;
  assign head_c       = mem_q[rd_ptr_q];

  // Slots committed next cycle: occupancy after this edge plus the read now in flight.
  assign used_c = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(push_c) + (CNT_W+1)'(rd_en_q)
                - (CNT_W+1)'(pop_c);
  assign credit_ok_c = (used_c < (CNT_W+1)'(FIFO_DEPTH));

  assign push_beat_c = '{man:      i_man_rd_data,
                         exp:      i_exp_rd_data,
                         grp:      ret_grp_q,
                         last_grp: (ret_grp_q == 2'(NV_LINES - 1)),
                         last:     ret_last_q};

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    total_d   = total_q;
    issued_d  = issued_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_grp_d  = rd_grp_q;
    rd_last_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          base_d   = {i_cmd_nv_start, 2'b00};
          total_d  = {i_cmd_nv_count, 2'b00};
          issued_d = '0;
          if (i_cmd_nv_count == '0) begin
            state_d = S_DONE;
          end else begin
            // Pipeline is empty on entry, so the first read needs no credit check.
            state_d   = S_ISSUE;
            rd_en_d   = 1'b1;
            rd_addr_d = {i_cmd_nv_start, 2'b00};
            rd_grp_d  = 2'd0;
            issued_d  = LINE_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (credit_ok_c) begin
          rd_en_d   = 1'b1;
          rd_addr_d = base_q + issued_q[ADDR_WIDTH-1:0];
          rd_grp_d  = issued_q[1:0];
          rd_last_d = (issued_q == total_q - LINE_W'(1));
          issued_d  = issued_q + LINE_W'(1);
          if (issued_q + LINE_W'(1) == total_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop_c && head_c.last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      total_q     <= '0;
      issued_q    <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_grp_q    <= '0;
      rd_last_q   <= 1'b0;
      ret_q       <= 1'b0;
      ret_grp_q   <= '0;
      ret_last_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      total_q     <= total_d;
      issued_q    <= issued_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_grp_q    <= rd_grp_d;
      rd_last_q   <= rd_last_d;
      ret_q       <= rd_en_q;
      ret_grp_q   <= rd_grp_q;
      ret_last_q  <= rd_last_q;
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // FIFO storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge i_clk) begin
    if (push_c) mem_q[wr_ptr_q] <= push_beat_c;
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_man_rd_en   = rd_en_q;
  assign o_man_rd_addr = rd_addr_q;
  assign o_exp_rd_addr = rd_addr_q;
  assign o_valid       = fifo_valid_c;
  assign o_man_data    = fifo_valid_c ? head_c.man      : '0;
  assign o_exp_data    = fifo_valid_c ? head_c.exp      : '0;
  assign o_grp_idx     = fifo_valid_c ? head_c.grp      : '0;
  assign o_last_grp    = fifo_valid_c && head_c.last_grp;
  assign o_last        = fifo_valid_c && head_c.last;

`ifdef TILE_RD_PERF_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of backpressured cycles, restarted per command.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      stall_q <= '0;
    end else if (accept_c) begin
      stall_q <= '0;
    end else if (fifo_valid_c && !i_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign o_stall_cycles = stall_q;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_tile_nv_reader.sv
// Directed vector bench for tile_nv_reader with a registered-read BRAM model.
module tb_tile_nv_reader;

  localparam int DEPTH = 512;
  localparam int WIDTH = 256;
  localparam int AW    = 9;
  localparam int FD    = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-3:0]    nv_start;
  logic [AW-2:0]    nv_count;
  logic [AW-1:0]    man_rd_addr;
  logic             man_rd_en;
  logic [WIDTH-1:0] man_rd_data;
  logic [AW-1:0]    exp_rd_addr;
  logic [7:0]       exp_rd_data;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] man_data;
  logic [7:0]       exp_data;
  logic [1:0]       grp_idx;
  logic             last_grp;
  logic             last;
  logic             busy;
  logic             done;
  logic [31:0]      stall_cycles;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] man_mem [DEPTH];
  logic [7:0]       exp_mem [DEPTH];

  typedef struct {
    int start;
    int count;
    int mode;       // 0: ready always high, 1: ready 1 cycle on / 3 off
    int exp_beats;
    int exp_first;  // first read address
    int exp_last;   // final read address
  } vec_t;

  vec_t vecs [6];

  tile_nv_reader dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_nv_start (nv_start),
    .i_cmd_nv_count (nv_count),
    .o_man_rd_addr  (man_rd_addr),
    .o_man_rd_en    (man_rd_en),
    .i_man_rd_data  (man_rd_data),
    .o_exp_rd_addr  (exp_rd_addr),
    .i_exp_rd_data  (exp_rd_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_man_data     (man_data),
    .o_exp_data     (exp_data),
    .o_grp_idx      (grp_idx),
    .o_last_grp     (last_grp),
    .o_last         (last),
    .o_busy         (busy),
    .o_done         (done),
    .o_stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (man_rd_en) begin
      man_rd_data <= man_mem[man_rd_addr];
      exp_rd_data <= exp_mem[exp_rd_addr];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic chk_w(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic do_cmd(input vec_t v, input int vi);
    int n, beats, issues, stalls, phase, first_valid, done_cyc, first_addr, last_addr, a;
    bit rdy, prev_stall, finished;
    logic [WIDTH-1:0] saved_man;
    int saved_tags;
    n = v.count * 4;
    beats = 0; issues = 0; stalls = 0; phase = 0;
    first_valid = -1; done_cyc = -1; first_addr = -1; last_addr = -1;
    prev_stall = 0; finished = 0; saved_man = '0; saved_tags = 0;

    @(negedge clk);
    cmd_valid = 1'b1;
    nv_start  = 7'(v.start);
    nv_count  = 8'(v.count);
    chk_int($sformatf("v%0d cmd_ready", vi), int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      rdy = (v.mode == 0) ? 1'b1 : ((phase % 4) == 0);
      phase++;
      i_ready = rdy;

      if (man_rd_en) begin
        a = (v.start * 4 + issues) % DEPTH;
        chk_int($sformatf("v%0d rd_addr[%0d]", vi, issues), int'(man_rd_addr), a);
        chk_int($sformatf("v%0d exp_addr[%0d]", vi, issues), int'(exp_rd_addr), a);
        chk_int($sformatf("v%0d credit_ok[%0d]", vi, issues), int'((issues + 1 - beats) <= FD), 1);
        if (v.mode == 0) chk_int($sformatf("v%0d issue_cycle[%0d]", vi, issues), cyc, issues);
        if (issues == 0) first_addr = int'(man_rd_addr);
        last_addr = int'(man_rd_addr);
        issues++;
      end

      if (prev_stall) begin
        chk_w($sformatf("v%0d stable_man", vi), man_data, saved_man);
        chk_int($sformatf("v%0d stable_tags", vi),
                int'({o_valid, exp_data, grp_idx, last_grp, last}), saved_tags);
      end

      if (o_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (rdy) begin
          a = (v.start * 4 + beats) % DEPTH;
          chk_w($sformatf("v%0d beat%0d man", vi, beats), man_data, man_mem[a]);
          chk_int($sformatf("v%0d beat%0d exp/grp/lastgrp/last", vi, beats),
                  int'({exp_data, grp_idx, last_grp, last}),
                  int'({exp_mem[a], 2'(beats % 4), (beats % 4) == 3, beats == n - 1}));
          beats++;
          prev_stall = 0;
        end else begin
          stalls++;
          prev_stall = 1;
          saved_man  = man_data;
          saved_tags = int'({1'b1, exp_data, grp_idx, last_grp, last});
        end
      end else begin
        prev_stall = 0;
      end

      if (done) begin
        finished = 1;
        done_cyc = cyc;
`ifdef TILE_RD_PERF_CNT_EN
        chk_int($sformatf("v%0d stall_cycles", vi), int'(stall_cycles), stalls);
`else
        chk_int($sformatf("v%0d stall_cycles", vi), int'(stall_cycles), 0);
`endif
      end
    end

    chk_int($sformatf("v%0d done_seen", vi), int'(finished), 1);
    chk_int($sformatf("v%0d beats", vi), beats, v.exp_beats);
    chk_int($sformatf("v%0d issues", vi), issues, v.exp_beats);
    if (n > 0) begin
      chk_int($sformatf("v%0d first_addr", vi), first_addr, v.exp_first);
      chk_int($sformatf("v%0d last_addr", vi), last_addr, v.exp_last);
      if (v.mode == 0) chk_int($sformatf("v%0d first_valid_latency", vi), first_valid, 2);
    end else begin
      chk_int($sformatf("v%0d done_latency", vi), done_cyc, 0);
    end

    @(negedge clk);
    i_ready = 1'b0;
    chk_int($sformatf("v%0d post_done done/valid/busy/ready", vi),
            int'({done, o_valid, busy, cmd_ready}), int'(4'b0001));
  endtask

  initial begin
    int beats;

    for (int a = 0; a < DEPTH; a++) begin
      for (int w = 0; w < 8; w++) man_mem[a][w*32 +: 32] = {8'(w), 8'hA5, 16'(a)};
      exp_mem[a] = 8'(a) ^ 8'h5A;
    end
    for (int a = 8; a < 12; a++) exp_mem[a] = 8'h10 + 8'(a - 8);

    vecs[0] = '{start: 0,   count: 1,   mode: 0, exp_beats: 4,   exp_first: 0,   exp_last: 3};
    vecs[1] = '{start: 2,   count: 1,   mode: 0, exp_beats: 4,   exp_first: 8,   exp_last: 11};
    vecs[2] = '{start: 127, count: 2,   mode: 0, exp_beats: 8,   exp_first: 508, exp_last: 3};
    vecs[3] = '{start: 10,  count: 16,  mode: 1, exp_beats: 64,  exp_first: 40,  exp_last: 103};
    vecs[4] = '{start: 5,   count: 0,   mode: 0, exp_beats: 0,   exp_first: 0,   exp_last: 0};
    vecs[5] = '{start: 64,  count: 128, mode: 0, exp_beats: 512, exp_first: 256, exp_last: 255};

    reset_n = 1'b0; cmd_valid = 1'b0; nv_start = '0; nv_count = '0; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_int("reset cmd_ready/valid/rd_en/busy/done", int'({cmd_ready, o_valid, man_rd_en, busy, done}), 0);
    chk_int("reset stall_cycles", int'(stall_cycles), 0);
    chk_w("reset man_data", man_data, '0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_int("post-reset cmd_ready", int'(cmd_ready), 1);

    for (int i = 0; i < 6; i++) do_cmd(vecs[i], i);

    // Reset in the middle of an 8-NV command after 5 beats have been taken.
    @(negedge clk);
    cmd_valid = 1'b1; nv_start = 7'd0; nv_count = 8'd8;
    @(negedge clk);
    cmd_valid = 1'b0; i_ready = 1'b1;
    beats = 0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) @(negedge clk);
      if (o_valid) beats++;
      if (beats == 5) break;
    end
    chk_int("midreset beats_before", beats, 5);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk_int("midreset cmd_ready/valid/rd_en/busy/done/last",
            int'({cmd_ready, o_valid, man_rd_en, busy, done, last, last_grp}), 0);
    chk_int("midreset addr/exp/grp", int'({man_rd_addr, exp_rd_addr, exp_data, grp_idx}), 0);
    chk_w("midreset man_data", man_data, '0);
    reset_n = 1'b1;
    i_ready = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (done || o_valid || man_rd_en) seen++;
      end
      chk_int("midreset no residual activity", seen, 0);
    end
    chk_int("midreset cmd_ready back", int'(cmd_ready), 1);
    do_cmd(vecs[0], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_nv_reader.md
Name: tile_nv_reader

Overview:
- Read sequencer between a tile's private L1 BRAM (mantissa and exponent arrays) and compute_engine_modular.
- Accepts a command of the form (start NV, NV count).
- Issues one mantissa line read plus the matching exponent read per group, hiding the 1-cycle registered BRAM read latency.
- Presents a backpressured valid/ready stream of {mantissa line, exponent, group tags} to the compute engine.

Parameters:
- DEPTH, 512, lines/entries per BRAM (128 NVs × 4).
- WIDTH, 256, mantissa line width in bits.
- ADDR_WIDTH, $clog2(DEPTH), BRAM address width.
- NV_LINES, 4, lines (groups) per Native Vector; fixed at 4.
- FIFO_DEPTH, 4, output skid FIFO entries; power of 2, ≥2.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous active-low reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_nv_start  in  ADDR_WIDTH-2  first NV index
- i_cmd_nv_count  in  ADDR_WIDTH-1  NVs to read, 0..128
- o_man_rd_addr  out  ADDR_WIDTH  mantissa BRAM read address
- o_man_rd_en  out  1  mantissa BRAM read enable
- i_man_rd_data  in  WIDTH  mantissa read data, valid 1 cycle after o_man_rd_en
- o_exp_rd_addr  out  ADDR_WIDTH  exponent read address; always equals o_man_rd_addr
- i_exp_rd_data  in  8  exponent read data, same timing as mantissa
- o_valid  out  1  output beat valid
- i_ready  in  1  consumer ready
- o_man_data  out  WIDTH  mantissa line
- o_exp_data  out  8  group exponent
- o_grp_idx  out  2  group index within NV
- o_last_grp  out  1  beat is group 3 of its NV
- o_last  out  1  final beat of command
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse when command completes
- o_stall_cycles  out  32  optional perf counter

Behaviour:
- Reset values: o_cmd_ready=0 during reset then 1; all other outputs 0. FIFO empty, counters cleared, state IDLE.
- Reset mid-command aborts immediately: FIFO flushed, in-flight read data discarded, no o_done.
- Command handshake: a command is accepted on i_cmd_valid && o_cmd_ready.
  - Latch base=i_cmd_nv_start×4 and total=i_cmd_nv_count×4 lines.
  - count=0: no reads, o_done pulses the next cycle, return to IDLE.
- States:
  - IDLE: wait for a command.
  - ISSUE: issue reads until all lines are issued, then go to DRAIN.
  - DRAIN: wait for the FIFO to empty and nothing to be in flight; on the final beat's handshake pulse o_done and go to IDLE.
- Issue rule: o_man_rd_en=1 in ISSUE iff credits > 0, where credits = FIFO_DEPTH − occupancy − inflight(0/1).
  - o_man_rd_addr = (base + line_idx) mod DEPTH; wraps 511→0.
- Read return: the cycle after o_man_rd_en, push {i_man_rd_data, i_exp_rd_data, grp=line_idx[1:0], last_grp, last} into the FIFO.
  - A push is never dropped; credit accounting guarantees space.
- Output: o_valid = FIFO non-empty. Pop on o_valid && i_ready. Data is held stable while o_valid && !i_ready.
- Throughput: with i_ready held high, 1 beat/cycle sustained. First o_valid appears 2 cycles after command acceptance (issue, BRAM return, FIFO registered output).
- Simultaneous push and pop on a full FIFO is permitted; occupancy is unchanged.
- o_last asserts with o_grp_idx=3 and o_last_grp=1 on the final line.
- A new command is accepted no earlier than the cycle after o_done.

Optional Feature:
- TILE_RD_PERF_CNT_EN defined: o_stall_cycles counts cycles with o_valid && !i_ready.
  - Saturates at 2^32−1.
  - Cleared on reset and on each command acceptance.
- Undefined: o_stall_cycles is tied to 0 and no counter logic exists.

Test Plan:
- Cmd start=0 count=1, i_ready=1 → reads at addrs 0,1,2,3 on consecutive cycles; 4 beats with grp 0..3; o_last_grp and o_last on beat 4; o_done once.
- Preload exp[8..11]=0x10..0x13 and mantissa lines with distinct patterns; cmd start=2 count=1 → o_exp_data 0x10,0x11,0x12,0x13 paired with mantissa lines 8..11.
- Cmd start=127 count=2 → addresses 508..511 then 0..3 (wrap); 8 beats, o_last only on the 8th.
- Cmd count=16, i_ready toggling 1 cycle on / 3 off → no lost or duplicated beats; o_man_rd_en never issued with zero credit; data stable during stalls; with the macro on, o_stall_cycles equals the number of stalled cycles.
- Cmd count=0 → no o_man_rd_en; o_done pulses 1 cycle after acceptance.
- Reset asserted mid-command (count=8, after 5 beats) → all outputs 0, o_valid=0, no o_done; next cmd start=0 count=1 executes cleanly.
